// File: rtl/stickman_motion_ctrl_if.sv
// Bundle of the stickman controller's keyboard/collision inputs and its
// sprite/score outputs. The game side (master) drives keycode and collide;
// the controller (slave) returns position, speed, state and score.
interface stickman_motion_ctrl_if;
   logic [7:0]  keycode;
   logic        collide;
   logic [9:0]  Y_Pos;
   logic [3:0]  Y_Vel;
   logic [2:0]  state;
   logic        airborne;
   logic        game_over;
   logic [15:0] score;

   modport master (
      output keycode, collide,
      input  Y_Pos, Y_Vel, state, airborne, game_over, score
   );

   modport slave (
      input  keycode, collide,
      output Y_Pos, Y_Vel, state, airborne, game_over, score
   );
endinterface

// File: rtl/stickman_motion_ctrl.sv
// stickman_motion_ctrl: per-frame vertical motion and game-state controller.
// A synchronised frame_clk rising edge produces a one-Clk tick; on each tick
// the FSM (IDLE/GROUND/RISE/FALL/DEAD) advances, the head Y position moves by
// the current speed under gravity, and the survival score counts up.
module stickman_motion_ctrl #(
   parameter logic [9:0] Y_GROUND  = 10'd300,
   parameter logic [9:0] Y_CEIL    = 10'd10,
   parameter logic [3:0] JUMP_V0   = 4'd8,
   parameter logic [3:0] GRAVITY   = 4'd1,
   parameter logic [3:0] MAX_FALL  = 4'd8,
   parameter logic [7:0] KEY_JUMP  = 8'h2c,
   parameter logic [7:0] KEY_START = 8'h28
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         frame_clk,
   stickman_motion_ctrl_if.slave        motion
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      GROUND = 3'd1,
      RISE   = 3'd2,
      FALL   = 3'd3,
      DEAD   = 3'd4
   } state_t;

   // Score counter that sticks at its maximum instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] s);
      return (s == 16'hFFFF) ? s : s + 16'd1;
   endfunction

   logic        fc_sync1_q, fc_sync2_q, fc_dly_q;
   logic        tick;
   state_t      state_q, state_d;
   logic [9:0]  y_q, y_d;
   logic [3:0]  v_q, v_d;
   logic [15:0] score_q, score_d;
   logic        jp_prev_q, jp_prev_d;

   logic        key_jump, key_start, jump_req;
   logic [4:0]  vsum_w;
   logic [3:0]  vn_w;
   logic [10:0] y_w, rise_lim_w, fall_sum_w;

   // Two-flop synchroniser plus delay flop; preset to 1 so a tick needs a
   // genuine low-to-high frame_clk transition after reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fc_sync1_q <= 1'b1;
         fc_sync2_q <= 1'b1;
         fc_dly_q   <= 1'b1;
      end else begin
         fc_sync1_q <= frame_clk;
         fc_sync2_q <= fc_sync1_q;
         fc_dly_q   <= fc_sync2_q;
      end
   end

   assign tick      = fc_sync2_q & ~fc_dly_q;
   assign key_jump  = (motion.keycode == KEY_JUMP);
   assign key_start = (motion.keycode == KEY_START);
   assign jump_req  = key_jump & ~jp_prev_q;

   // Fall speed after gravity, capped at terminal speed; position sums are
   // kept one bit wider so comparisons never wrap.
   assign vsum_w     = {1'b0, v_q} + {1'b0, GRAVITY};
   assign vn_w       = (vsum_w > {1'b0, MAX_FALL}) ? MAX_FALL : vsum_w[3:0];
   assign y_w        = {1'b0, y_q};
   assign rise_lim_w = {1'b0, Y_CEIL} + {7'd0, v_q};
   assign fall_sum_w = y_w + {7'd0, vn_w};

   // State, position, speed, score and jump-key history registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         y_q       <= Y_GROUND;
         v_q       <= 4'd0;
         score_q   <= 16'd0;
         jp_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         y_q       <= y_d;
         v_q       <= v_d;
         score_q   <= score_d;
         jp_prev_q <= jp_prev_d;
      end
   end

   // Next-state and motion update, applied only on frame ticks.
   always_comb begin
      state_d   = state_q;
      y_d       = y_q;
      v_d       = v_q;
      score_d   = score_q;
      jp_prev_d = jp_prev_q;
      if (tick) begin
         jp_prev_d = key_jump;
         case (state_q)
            IDLE: begin
               y_d = Y_GROUND;
               v_d = 4'd0;
               if (key_start) begin
                  state_d = GROUND;
                  score_d = 16'd0;
               end
            end
            GROUND: begin
               if (motion.collide) begin
                  state_d = DEAD;
               end else begin
                  score_d = sat_inc(score_q);
                  if (jump_req) begin
                     state_d = RISE;
                     v_d     = JUMP_V0;
                  end
               end
            end
            RISE: begin
               if (motion.collide) begin
                  state_d = DEAD;
               end else begin
                  score_d = sat_inc(score_q);
                  if (y_w < rise_lim_w) begin
                     y_d     = Y_CEIL;
                     v_d     = 4'd0;
                     state_d = FALL;
                  end else begin
                     y_d = y_q - {6'd0, v_q};
                     if (v_q <= GRAVITY) begin
                        v_d     = 4'd0;
                        state_d = FALL;
                     end else begin
                        v_d = v_q - GRAVITY;
                     end
                  end
               end
            end
            FALL: begin
               if (motion.collide) begin
                  state_d = DEAD;
               end else begin
                  score_d = sat_inc(score_q);
                  if (fall_sum_w >= {1'b0, Y_GROUND}) begin
                     y_d     = Y_GROUND;
                     v_d     = 4'd0;
                     state_d = GROUND;
                  end else begin
                     y_d = fall_sum_w[9:0];
                     v_d = vn_w;
                  end
               end
            end
            DEAD: begin
               if (key_start) begin
                  state_d = IDLE;
                  y_d     = Y_GROUND;
                  v_d     = 4'd0;
               end
            end
            default: begin
               state_d = IDLE;
               y_d     = Y_GROUND;
               v_d     = 4'd0;
            end
         endcase
      end
   end

   assign motion.Y_Pos     = y_q;
   assign motion.Y_Vel     = v_q;
   assign motion.state     = state_q;
   assign motion.airborne  = (state_q == RISE) || (state_q == FALL);
   assign motion.game_over = (state_q == DEAD);
   assign motion.score     = score_q;

endmodule

// File: tb/tb_stickman_motion_ctrl.sv
// Directed bench for stickman_motion_ctrl: start, full jump arc, ceiling
// clamp, collision/death, asynchronous reset mid-jump, score saturation.
module tb_stickman_motion_ctrl;

   localparam logic [7:0] K_JUMP  = 8'h2c;
   localparam logic [7:0] K_START = 8'h28;

   logic Clk;
   logic Reset_n;
   logic frame_clk;

   int n_vec;
   int n_err;
   int exp_score;

   int arc_y [20] = '{300, 292, 285, 279, 274, 270, 267, 265, 264,
                      265, 267, 270, 274, 279, 285, 292, 300, 300, 300, 300};

   stickman_motion_ctrl_if ifa ();
   stickman_motion_ctrl_if ifc ();

   stickman_motion_ctrl dut_a (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .frame_clk (frame_clk),
      .motion    (ifa.slave)
   );

   stickman_motion_ctrl #(.Y_CEIL(10'd280)) dut_c (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .frame_clk (frame_clk),
      .motion    (ifc.slave)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   // One frame: frame_clk high for 4 Clk, low for 4 Clk; outputs settled after.
   task automatic tick_frame();
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   task automatic test_reset();
      Reset_n   = 1'b0;
      frame_clk = 1'b0;
      ifa.keycode = 8'h00; ifa.collide = 1'b0;
      ifc.keycode = 8'h00; ifc.collide = 1'b0;
      repeat (3) @(negedge Clk);
      n_vec++; if (ifa.state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", ifa.state); end
      n_vec++; if (ifa.Y_Pos !== 10'd300) begin n_err++; $display("FAIL reset_ypos: got %0d expected 300", ifa.Y_Pos); end
      n_vec++; if (ifa.Y_Vel !== 4'd0) begin n_err++; $display("FAIL reset_yvel: got %0d expected 0", ifa.Y_Vel); end
      n_vec++; if (ifa.score !== 16'd0) begin n_err++; $display("FAIL reset_score: got %0d expected 0", ifa.score); end
      n_vec++; if (ifa.airborne !== 1'b0 || ifa.game_over !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b%b expected 00", ifa.airborne, ifa.game_over); end
      @(negedge Clk);
      Reset_n = 1'b1;
      repeat (4) @(negedge Clk);
      n_vec++; if (ifa.state !== 3'd0) begin n_err++; $display("FAIL idle_no_tick: got %0d expected 0", ifa.state); end
   endtask

   task automatic test_start();
      ifa.keycode = K_START;
      tick_frame();
      n_vec++; if (ifa.state !== 3'd1) begin n_err++; $display("FAIL start_state: got %0d expected 1", ifa.state); end
      n_vec++; if (ifa.Y_Pos !== 10'd300) begin n_err++; $display("FAIL start_ypos: got %0d expected 300", ifa.Y_Pos); end
      n_vec++; if (ifa.score !== 16'd0) begin n_err++; $display("FAIL start_score: got %0d expected 0", ifa.score); end
      ifa.keycode = 8'h00;
      repeat (4) tick_frame();
      exp_score = 4;
      n_vec++; if (ifa.score !== 16'(exp_score)) begin n_err++; $display("FAIL ground_score: got %0d expected %0d", ifa.score, exp_score); end
   endtask

   task automatic test_jump_arc();
      logic [2:0] exp_st;
      ifa.keycode = K_JUMP;
      for (int i = 0; i < 20; i++) begin
         tick_frame();
         exp_score++;
         exp_st = (i < 8) ? 3'd2 : ((i < 16) ? 3'd3 : 3'd1);
         n_vec++; if (ifa.Y_Pos !== 10'(arc_y[i])) begin n_err++; $display("FAIL arc_ypos[%0d]: got %0d expected %0d", i, ifa.Y_Pos, arc_y[i]); end
         n_vec++; if (ifa.state !== exp_st) begin n_err++; $display("FAIL arc_state[%0d]: got %0d expected %0d", i, ifa.state, exp_st); end
         n_vec++; if (ifa.airborne !== (exp_st != 3'd1)) begin n_err++; $display("FAIL arc_airborne[%0d]: got %b expected %b", i, ifa.airborne, exp_st != 3'd1); end
      end
      n_vec++; if (ifa.Y_Vel !== 4'd0) begin n_err++; $display("FAIL arc_land_vel: got %0d expected 0", ifa.Y_Vel); end
      n_vec++; if (ifa.score !== 16'(exp_score)) begin n_err++; $display("FAIL arc_score: got %0d expected %0d", ifa.score, exp_score); end
      ifa.keycode = 8'h00;
   endtask

   task automatic test_ceiling();
      ifc.keycode = K_START;
      tick_frame();
      exp_score++;
      n_vec++; if (ifc.state !== 3'd1) begin n_err++; $display("FAIL ceil_start: got %0d expected 1", ifc.state); end
      ifc.keycode = K_JUMP;
      tick_frame();
      exp_score++;
      n_vec++; if (ifc.state !== 3'd2 || ifc.Y_Vel !== 4'd8) begin n_err++; $display("FAIL ceil_launch: got state %0d vel %0d expected 2/8", ifc.state, ifc.Y_Vel); end
      tick_frame();
      exp_score++;
      n_vec++; if (ifc.Y_Pos !== 10'd292) begin n_err++; $display("FAIL ceil_y1: got %0d expected 292", ifc.Y_Pos); end
      tick_frame();
      exp_score++;
      n_vec++; if (ifc.Y_Pos !== 10'd285) begin n_err++; $display("FAIL ceil_y2: got %0d expected 285", ifc.Y_Pos); end
      tick_frame();
      exp_score++;
      n_vec++; if (ifc.Y_Pos !== 10'd280) begin n_err++; $display("FAIL ceil_clamp: got %0d expected 280", ifc.Y_Pos); end
      n_vec++; if (ifc.state !== 3'd3 || ifc.Y_Vel !== 4'd0) begin n_err++; $display("FAIL ceil_fall: got state %0d vel %0d expected 3/0", ifc.state, ifc.Y_Vel); end
      ifc.keycode = 8'h00;
      n_vec++; if (ifa.score !== 16'(exp_score)) begin n_err++; $display("FAIL idle_key_score: got %0d expected %0d", ifa.score, exp_score); end
   endtask

   task automatic test_collision();
      ifa.keycode = K_JUMP;
      repeat (5) begin
         tick_frame();
         exp_score++;
      end
      n_vec++; if (ifa.Y_Pos !== 10'd274) begin n_err++; $display("FAIL coll_pre_y: got %0d expected 274", ifa.Y_Pos); end
      ifa.keycode = K_JUMP;
      ifa.collide = 1'b1;
      tick_frame();
      n_vec++; if (ifa.state !== 3'd4 || ifa.game_over !== 1'b1) begin n_err++; $display("FAIL coll_dead: got state %0d go %b expected 4/1", ifa.state, ifa.game_over); end
      n_vec++; if (ifa.Y_Pos !== 10'd274 || ifa.Y_Vel !== 4'd4) begin n_err++; $display("FAIL coll_hold: got y %0d vel %0d expected 274/4", ifa.Y_Pos, ifa.Y_Vel); end
      ifa.keycode = 8'h00;
      for (int i = 0; i < 10; i++) begin
         ifa.collide = (i < 5);
         tick_frame();
         n_vec++; if (ifa.Y_Pos !== 10'd274 || ifa.score !== 16'(exp_score) || ifa.state !== 3'd4) begin
            n_err++; $display("FAIL dead_hold[%0d]: got y %0d score %0d state %0d expected 274/%0d/4", i, ifa.Y_Pos, ifa.score, ifa.state, exp_score);
         end
      end
      ifa.keycode = K_START;
      tick_frame();
      n_vec++; if (ifa.state !== 3'd0 || ifa.game_over !== 1'b0) begin n_err++; $display("FAIL restart_state: got state %0d go %b expected 0/0", ifa.state, ifa.game_over); end
      n_vec++; if (ifa.Y_Pos !== 10'd300 || ifa.Y_Vel !== 4'd0) begin n_err++; $display("FAIL restart_y: got y %0d vel %0d expected 300/0", ifa.Y_Pos, ifa.Y_Vel); end
      ifa.keycode = 8'h00;
   endtask

   task automatic test_reset_mid_jump();
      ifa.keycode = K_START;
      tick_frame();
      ifa.keycode = K_JUMP;
      tick_frame();
      tick_frame();
      n_vec++; if (ifa.state !== 3'd2 || ifa.Y_Pos !== 10'd292) begin n_err++; $display("FAIL mid_pre: got state %0d y %0d expected 2/292", ifa.state, ifa.Y_Pos); end
      @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      n_vec++; if (ifa.state !== 3'd0 || ifa.Y_Pos !== 10'd300) begin n_err++; $display("FAIL mid_async: got state %0d y %0d expected 0/300", ifa.state, ifa.Y_Pos); end
      n_vec++; if (ifa.score !== 16'd0 || ifa.Y_Vel !== 4'd0 || ifa.airborne !== 1'b0) begin n_err++; $display("FAIL mid_async_regs: got score %0d vel %0d air %b expected 0/0/0", ifa.score, ifa.Y_Vel, ifa.airborne); end
      frame_clk = 1'b1;
      ifa.keycode = K_START;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      repeat (10) @(negedge Clk);
      n_vec++; if (ifa.state !== 3'd0) begin n_err++; $display("FAIL no_tick_after_reset: got %0d expected 0", ifa.state); end
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
      tick_frame();
      n_vec++; if (ifa.state !== 3'd1) begin n_err++; $display("FAIL tick_resumes: got %0d expected 1", ifa.state); end
      ifa.keycode = 8'h00;
   endtask

   task automatic test_score_saturation();
      @(negedge Clk);
      force dut_a.score_q = 16'hFFFE;
      @(negedge Clk);
      release dut_a.score_q;
      for (int i = 0; i < 3; i++) begin
         tick_frame();
         n_vec++; if (ifa.score !== 16'hFFFF) begin n_err++; $display("FAIL score_sat[%0d]: got %h expected ffff", i, ifa.score); end
      end
      n_vec++; if (ifa.state !== 3'd1) begin n_err++; $display("FAIL sat_state: got %0d expected 1", ifa.state); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      exp_score = 0;
      test_reset();
      test_start();
      test_jump_arc();
      test_ceiling();
      test_collision();
      test_reset_mid_jump();
      test_score_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
